spi_slave_rsp: RTL
==================

Name: spi_slave_rsp

Overview:
- SPI responder (slave) for the serial end of the SPI master link; verification bench uses it as the far-end device and it is reusable in RTL.
- Oversamples SCK/SS/MOSI on the system clock, shifts 8-bit frames in both directions, and presents a parallel byte interface with a TX holding register and byte-complete interrupt.
- Supports all four CPOL/CPHA modes and MSB/LSB-first ordering.

Parameters:
- DATA_W, 8, frame width in bits (bit counter is clog2(DATA_W) wide)
- SYNC_STAGES, 2, synchronizer depth on i_sck, i_ss_n, i_mosi (min 2)
- IDLE_FILL, 8'hFF, byte shifted out when no TX data is queued

Ports:
- clk  input  1  system clock; single clock domain
- rst  input  1  synchronous, active-high reset
- cfg_cpol  input  1  clock polarity
- cfg_cpha  input  1  clock phase
- cfg_lsb_first  input  1  1 = LSB first, 0 = MSB first
- i_tx_data  input  DATA_W  byte to transmit on MISO
- i_tx_valid  input  1  TX data offered
- o_tx_ready  output  1  TX holding register empty
- o_rx_data  output  DATA_W  last complete received byte
- o_rx_valid  output  1  one-cycle pulse, o_rx_data updated
- o_irq  output  1  sticky byte-complete interrupt
- i_irq_clr  input  1  clears o_irq
- o_busy  output  1  frame in progress (SS asserted)
- i_sck  input  1  SPI clock from master (async)
- i_ss_n  input  1  slave select, active low (async)
- i_mosi  input  1  master-out data (async)
- o_miso  output  1  slave-out data
- o_miso_oe  output  1  MISO driver enable; 0 = high-Z at pad

Behaviour:
- Reset (rst=1 at posedge clk): state IDLE; o_tx_ready=1, o_rx_data=0, o_rx_valid=0, o_irq=0, o_busy=0, o_miso=1, o_miso_oe=0; holding register empty; synchronizers loaded to idle (sck=cfg_cpol, ss_n=1).
- i_sck/i_ss_n/i_mosi pass through SYNC_STAGES flops; edges are detected from the last two synchronized samples. Required: f_SCK <= f_clk/8.
- mode captured on SS falling edge; cfg_* changes while busy are ignored until next frame.
- Leading edge = transition away from CPOL level; trailing edge = return to it.
- FSM IDLE -> ACTIVE on synchronized SS falling edge:
  - shift register <- holding register if full (holding marked empty, o_tx_ready=1 next cycle), else IDLE_FILL.
  - bit_cnt=0, o_busy=1, o_miso_oe=1; CPHA=0: first bit on o_miso in the same cycle.
- ACTIVE, CPHA=0: sample MOSI on leading edge, shift next bit out on trailing edge. CPHA=1: shift out on leading, sample on trailing.
- Sample edge increments bit_cnt. On the DATA_W-th sample:
  - o_rx_data <= assembled byte, o_rx_valid=1 for 1 cycle, o_irq<=1, bit_cnt wraps to 0.
  - shift register reloads from holding register (or IDLE_FILL) for back-to-back bytes with SS held low.
- ACTIVE -> IDLE on synchronized SS rising edge, any bit_cnt: partial byte discarded (no o_rx_valid, o_irq unchanged), o_busy=0, o_miso_oe=0, o_miso=1.
- Holding register: written when i_tx_valid && o_tx_ready; o_tx_ready falls the next cycle. Write and reload in the same cycle: reload takes the old content, the new byte is accepted.
- o_irq set and i_irq_clr in the same cycle: set wins.
- rst mid-frame: immediate return to IDLE with reset values; the master's remaining clocks are ignored until a fresh SS falling edge.

Optional Feature:
- Macro SPI_SLAVE_OVR_DET_EN.
- Defined: adds output o_err [1:0], sticky, cleared by i_irq_clr.
  - bit0 = RX overrun: new byte completes while o_irq still set.
  - bit1 = TX underrun: IDLE_FILL loaded because holding register empty.
  - Reset value 0.
- Undefined: port absent, no error logic; overrun/underrun silently tolerated.

Test Plan:
- Mode 0, MSB first, tx 8'hA5 preloaded; master sends 8'h3C -> o_miso stream 1,0,1,0,0,1,0,1; o_rx_data=8'h3C with one o_rx_valid pulse; o_irq=1.
- Mode 3, LSB first, tx 8'h81; master sends 8'h01 -> MISO bits 1,0,0,0,0,0,0,1; o_rx_data=8'h01.
- Back-to-back: SS low for 16 SCKs, tx 8'h11 then 8'h22 queued after first o_tx_ready -> MISO carries 8'h11, 8'h22; two o_rx_valid pulses.
- No TX queued, mode 1 -> MISO shifts 8'hFF; with SPI_SLAVE_OVR_DET_EN, o_err[1]=1.
- SS deasserted after 5 SCKs -> no o_rx_valid, o_irq stays 0, o_miso_oe=0; next full frame received correctly.
- rst asserted at bit 4 -> all outputs at reset values next cycle; following frame 8'hC3 received intact.

Source files
------------

// File: rtl/spi_slave_rsp.sv
// SPI responder: oversampled SCK/SS/MOSI, 8-bit frames, all CPOL/CPHA modes.
// Optional sticky overrun/underrun flags on o_err when SPI_SLAVE_OVR_DET_EN is defined.
module spi_slave_rsp #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_FILL   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_irq,
  input  logic              i_irq_clr,
  output logic              o_busy,
`ifdef SPI_SLAVE_OVR_DET_EN
  output logic [1:0]        o_err,
`endif
  input  logic              i_sck,
  input  logic              i_ss_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  function automatic logic first_bit(input logic [DATA_W-1:0] v,
                                     input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_on(input logic [DATA_W-1:0] v,
                                                 input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  logic [SYNC_STAGES:0]   sck_q, ss_q, vld_q;
  logic [SYNC_STAGES-1:0] mosi_q;

  logic [0:0]        state_q, state_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d, hold_q, hold_d;
  logic              rx_valid_q, rx_valid_d, irq_q, irq_d;
  logic              miso_q, miso_d, hold_full_q, hold_full_d;
  logic              armed_q, armed_d;
  logic [1:0]        err_q, err_d;

  logic sck_s, sck_p, ss_s, ss_p, mosi_s;
  logic sck_rise, sck_fall, lead, trail, active;
  logic ss_fall, ss_rise, start, smp_evt, out_evt, done, load;
  logic [DATA_W-1:0] rx_asm, load_data;

  assign sck_s  = sck_q[SYNC_STAGES-1];
  assign sck_p  = sck_q[SYNC_STAGES];
  assign ss_s   = ss_q[SYNC_STAGES-1];
  assign ss_p   = ss_q[SYNC_STAGES];
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_p;
  assign sck_fall = ~sck_s & sck_p;
  assign lead     = cpol_q ? sck_fall : sck_rise;
  assign trail    = cpol_q ? sck_rise : sck_fall;

  // A fall only counts once SS has been seen high on real pin data,
  // so a reset in mid-frame waits for a fresh select.
  assign ss_fall = armed_q & ss_p & ~ss_s;
  assign ss_rise = ~ss_p & ss_s;
  assign active  = (state_q == ST_ACTIVE);
  assign start   = (state_q == ST_IDLE) & ss_fall;
  assign smp_evt = active & ~ss_rise & (cpha_q ? trail : lead);
  assign out_evt = active & ~ss_rise & (cpha_q ? lead : trail);
  assign done    = smp_evt & (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign load    = start | done;

  assign load_data = hold_full_q ? hold_q : IDLE_FILL;
  assign rx_asm    = lsb_q ? {mosi_s, rx_sr_q[DATA_W-1:1]}
                           : {rx_sr_q[DATA_W-2:0], mosi_s};

  // Input synchronizers plus one extra stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= {(SYNC_STAGES+1){cfg_cpol}};
      ss_q   <= '1;
      mosi_q <= '0;
      vld_q  <= '0;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-1:0], i_sck};
      ss_q   <= {ss_q[SYNC_STAGES-1:0], i_ss_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], i_mosi};
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Frame FSM, shifters, holding register and interrupt next-state.
  always_comb begin
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsb_d       = lsb_q;
    bit_cnt_d   = bit_cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    irq_d       = irq_q;
    miso_d      = miso_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    armed_d     = armed_q | (vld_q[SYNC_STAGES] & ss_s);
    err_d       = err_q;

    if (start) begin
      state_d   = ST_ACTIVE;
      cpol_d    = cfg_cpol;
      cpha_d    = cfg_cpha;
      lsb_d     = cfg_lsb_first;
      bit_cnt_d = '0;
      if (cfg_cpha) begin
        tx_sr_d = load_data;
      end else begin
        miso_d  = first_bit(load_data, cfg_lsb_first);
        tx_sr_d = shift_on(load_data, cfg_lsb_first);
      end
    end else if (active & ss_rise) begin
      state_d = ST_IDLE;
      miso_d  = 1'b1;
    end else begin
      if (out_evt) begin
        miso_d  = first_bit(tx_sr_q, lsb_q);
        tx_sr_d = shift_on(tx_sr_q, lsb_q);
      end
      if (smp_evt) begin
        rx_sr_d   = rx_asm;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (done) begin
          bit_cnt_d  = '0;
          rx_data_d  = rx_asm;
          rx_valid_d = 1'b1;
          tx_sr_d    = load_data;
        end
      end
    end

    if (i_tx_valid & ~hold_full_q) begin
      hold_d      = i_tx_data;
      hold_full_d = 1'b1;
    end else if (load & hold_full_q) begin
      hold_full_d = 1'b0;
    end

    if (i_irq_clr) begin
      irq_d = 1'b0;
      err_d = '0;
    end
    if (done) begin
      irq_d = 1'b1;
      if (irq_q) err_d[0] = 1'b1;
    end
    if (load & ~hold_full_q) err_d[1] = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      irq_q       <= 1'b0;
      miso_q      <= 1'b1;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      armed_q     <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsb_q       <= lsb_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      irq_q       <= irq_d;
      miso_q      <= miso_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      armed_q     <= armed_d;
      err_q       <= err_d;
    end
  end

  assign o_tx_ready = ~hold_full_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_irq      = irq_q;
  assign o_busy     = active;
  assign o_miso     = miso_q;
  assign o_miso_oe  = active;
`ifdef SPI_SLAVE_OVR_DET_EN
  assign o_err      = err_q;
`else
  logic unused_err;
  assign unused_err = ^err_q;
`endif

endmodule
